// File: rtl/cdf_pkg.sv
// rtl/cdf_pkg.sv - shared widths and fetch FSM encoding for the CDF pipeline
package cdf_pkg;

  localparam int BIN_W_DEF    = 20;
  localparam int ADDR_W_DEF   = 16;
  localparam int NUM_BINS_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/cdf_fetch_delay.sv
// rtl/cdf_fetch_delay.sv - {valid, index} shift register matching the SRAM read latency
module cdf_fetch_delay #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 8
) (
  input  logic             clock,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_index,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index
);

  logic [DEPTH-1:0] valid_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clock) begin
    if (flush) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      idx_q[0]   <= in_index;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_index = idx_q[DEPTH-1];

endmodule

// File: rtl/cdf_hist_fetch.sv
// rtl/cdf_hist_fetch.sv - walks histogram bins, realigns read data and emits the CDF input stream
module cdf_hist_fetch
  import cdf_pkg::*;
#(
  parameter int NUM_BINS      = NUM_BINS_DEF,
  parameter int BIN_W         = BIN_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int HIST_BASE     = 0,
  parameter int CDF_BASE      = 0,
  parameter int MEM_LATENCY   = 1,
  parameter int CLEAR_ON_READ = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [BIN_W-1:0]  mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [BIN_W-1:0]  mem_wr_data,
  output logic              start_out,
  output logic [BIN_W-1:0]  accum_out,
  output logic [ADDR_W-1:0] store_addr_out
);

  localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NUM_BINS - 1);

  fetch_state_t     state;
  logic [IDX_W-1:0] cnt;
  logic [2:0]       drain_cnt;
  logic             dly_valid;
  logic [IDX_W-1:0] dly_index;
  logic             clear_en;

  cdf_fetch_delay #(
    .DEPTH (MEM_LATENCY),
    .IDX_W (IDX_W)
  ) u_delay (
    .clock     (clock),
    .flush     (reset | abort),
    .in_valid  (mem_rd_en),
    .in_index  (cnt),
    .out_valid (dly_valid),
    .out_index (dly_index)
  );

  // cnt always names the bin whose read is on the bus this cycle
  always_ff @(posedge clock) begin
    if (reset || abort) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      drain_cnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            state       <= ST_ISSUE;
            cnt         <= '0;
            busy        <= 1'b1;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= ADDR_W'(HIST_BASE);
          end
        end
        ST_ISSUE: begin
          if (cnt == LAST_BIN) begin
            state       <= ST_DRAIN;
            drain_cnt   <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
          end else begin
            cnt         <= cnt + 1'b1;
            mem_rd_addr <= ADDR_W'(HIST_BASE) + ADDR_W'(cnt) + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          // last bin needs MEM_LATENCY cycles in flight plus one in the output register
          if (drain_cnt == 3'(MEM_LATENCY)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || abort || !dly_valid) begin
      start_out      <= 1'b0;
      accum_out      <= '0;
      store_addr_out <= '0;
    end else begin
      start_out      <= 1'b1;
      accum_out      <= mem_rd_data;
      store_addr_out <= ADDR_W'(CDF_BASE) + ADDR_W'(dly_index);
    end
  end

  // write address trails the read address by MEM_LATENCY, so a dual-port SRAM never collides
  assign clear_en    = (CLEAR_ON_READ != 0) && dly_valid;
  assign mem_wr_en   = clear_en;
  assign mem_wr_addr = clear_en ? ADDR_W'(HIST_BASE) + ADDR_W'(dly_index) : '0;
  assign mem_wr_data = '0;

endmodule

// File: doc/cdf_hist_fetch.md
Name: cdf_hist_fetch

Overview:
- Front-end sequencer for the CDF pipeline. On a go pulse it walks histogram SRAM bins 0..NUM_BINS-1 and issues one read per cycle.
- It realigns the returned bin counts against the SRAM read latency. It then drives the contiguous start / bin-count / store-address stream that the downstream CDF accumulate stage consumes.
- Optionally zeroes each bin after reading it, which readies the histogram for the next frame.

Parameters:
- NUM_BINS, 256, number of histogram bins walked per run (>=2).
- BIN_W, 20, histogram bin / accumulate data width.
- ADDR_W, 16, SRAM and store address width.
- HIST_BASE, 0, SRAM address of bin 0.
- CDF_BASE, 0, store address emitted for bin 0.
- MEM_LATENCY, 1, cycles from mem_rd_en to valid mem_rd_data (1..4).
- CLEAR_ON_READ, 1, when 1, write zero back to each bin after its data returns.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous active-high reset.
- go  in  1  single-cycle start request, honoured only in IDLE.
- abort  in  1  synchronous cancel of the current run.
- busy  out  1  high from the cycle after an accepted go until done.
- done  out  1  one-cycle pulse at the end of a completed, non-aborted run.
- mem_rd_en  out  1  SRAM read strobe.
- mem_rd_addr  out  ADDR_W  SRAM read address.
- mem_rd_data  in  BIN_W  SRAM read data, valid MEM_LATENCY cycles after mem_rd_en.
- mem_wr_en  out  1  SRAM clear-write strobe; tied 0 when CLEAR_ON_READ=0.
- mem_wr_addr  out  ADDR_W  SRAM clear-write address.
- mem_wr_data  out  BIN_W  always zero.
- start_out  out  1  stream valid, feeds the accumulate stage start input.
- accum_out  out  BIN_W  bin count, feeds the accumulate data input.
- store_addr_out  out  ADDR_W  CDF store address for the bin on accum_out.

Behaviour:
- Reset values: every output 0; FSM in IDLE; bin counter 0; delay pipeline cleared.
- FSM states and transitions:
  - IDLE: go=1 -> ISSUE, bin counter=0.
  - ISSUE: mem_rd_en=1, mem_rd_addr=HIST_BASE+cnt, cnt increments every cycle. At cnt==NUM_BINS-1 -> DRAIN. Reads are never stalled.
  - DRAIN: waits MEM_LATENCY+1 cycles until the last bin has left the output register -> DONE.
  - DONE: done=1 for one cycle -> IDLE. busy is low in DONE.
- Alignment:
  - A delay line of depth MEM_LATENCY carries a valid bit and the bin index alongside each read.
  - When the delayed valid is 1, the outputs register on the next edge: start_out=1, accum_out=mem_rd_data, store_addr_out=CDF_BASE+index.
  - Latency from mem_rd_en for bin k to start_out carrying bin k is MEM_LATENCY+1 cycles.
- Stream contract:
  - start_out is high for exactly NUM_BINS consecutive cycles per run, with no bubbles.
  - start_out is low for at least one cycle between runs, so the downstream accumulator clears.
  - accum_out and store_addr_out are 0 whenever start_out=0.
- Clear-on-read:
  - In the cycle the delayed valid is 1: mem_wr_en=1, mem_wr_addr=HIST_BASE+index.
  - Read and clear never target the same address in the same cycle, because the write address lags the read address by MEM_LATENCY. A dual-port SRAM is required.
- Address arithmetic: address sums wrap modulo 2^ADDR_W; this is not an error.
- go handling:
  - go while busy or in DONE is ignored, with no queuing.
  - go in the same cycle done pulses is ignored; the new run needs go in IDLE.
- abort handling:
  - Any state -> IDLE on the next edge. Delay line is flushed.
  - mem_rd_en, mem_wr_en and start_out are 0 from the next cycle; no done pulse.
  - Priority: abort beats go.
- reset mid-run: same result as abort, plus all outputs are forced to reset values.

Decomposition:
- Shared package cdf_pkg holds:
  - BIN_W, ADDR_W and NUM_BINS defaults shared with the accumulate stage.
  - The FSM state encoding: IDLE=0, ISSUE=1, DRAIN=2, DONE=3.
- One sub-module, cdf_fetch_delay: a parameterised MEM_LATENCY-deep shift register of {valid, index} with a synchronous flush input.

Test Plan:
- NUM_BINS=4, MEM_LATENCY=1, SRAM bins {5,0,7,3}, go pulse -> mem_rd_en for addrs 0..3 on cycles 1..4; start_out high cycles 3..6 with accum_out 5,0,7,3 and store_addr_out 0..3; done pulse on cycle 7.
- Same run with MEM_LATENCY=3 -> start_out window shifts 2 cycles later and stays 4 contiguous cycles; done is 2 cycles later.
- CLEAR_ON_READ=1 -> mem_wr_en pulses once per addr 0..3 with data 0; rereading the SRAM after done returns all zeros.
- go asserted during ISSUE and again in the DONE cycle -> ignored; exactly one run and one done pulse.
- abort on the 2nd ISSUE cycle -> start_out never exceeds 1 high cycle; mem_rd_en is 0 next cycle; no done; a fresh go restarts at addr 0.
- reset asserted mid-DRAIN -> all outputs 0 next cycle; busy=0; no done pulse.
